// File: rtl/score_keeper_pkg.sv
// Shared constants and helpers for score_keeper: judge codes, points, grade thresholds, FSM encodings.
// Optional full-combo tracking is enabled with SCORE_FULL_COMBO_EN.
package score_keeper_pkg;

   localparam int unsigned SCORE_W     = 21;
   localparam int unsigned DIV_W       = 32;
   localparam int unsigned NOTE_W      = 16;
   localparam int unsigned LEVEL_W     = 3;

   localparam int unsigned PERFECT_PTS = 300;
   localparam int unsigned GREAT_PTS   = 100;
   localparam int unsigned GOOD_PTS    = 50;
   localparam int unsigned ACC_SCALE   = 10000;
   localparam int unsigned DEN_STEP    = 3;
   localparam int unsigned COMBO_CAP   = 255;

   localparam int unsigned GRADE_SS    = 10000;
   localparam int unsigned GRADE_S     = 9500;
   localparam int unsigned GRADE_A     = 9000;
   localparam int unsigned GRADE_B     = 8000;
   localparam int unsigned GRADE_C     = 7000;

   localparam logic [NOTE_W-1:0] NOTE_CAP = 16'd65535;

   localparam logic [1:0] JUDGE_MISS    = 2'b00;
   localparam logic [1:0] JUDGE_GOOD    = 2'b01;
   localparam logic [1:0] JUDGE_GREAT   = 2'b10;
   localparam logic [1:0] JUDGE_PERFECT = 2'b11;

   localparam logic [1:0] MOD_X2        = 2'b01;
   localparam logic [1:0] MOD_HALF      = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_UPDATE = 2'd1;
   localparam logic [1:0] ST_DIVIDE = 2'd2;
   localparam logic [1:0] ST_GRADE  = 2'd3;

   function automatic logic [SCORE_W-1:0] judge_points(input logic [1:0] judge);
      case (judge)
         JUDGE_PERFECT: return SCORE_W'(PERFECT_PTS);
         JUDGE_GREAT:   return SCORE_W'(GREAT_PTS);
         JUDGE_GOOD:    return SCORE_W'(GOOD_PTS);
         default:       return '0;
      endcase
   endfunction

   function automatic logic [1:0] judge_weight(input logic [1:0] judge);
      case (judge)
         JUDGE_PERFECT: return 2'd3;
         JUDGE_GREAT:   return 2'd2;
         JUDGE_GOOD:    return 2'd1;
         default:       return 2'd0;
      endcase
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   endfunction

   function automatic logic [LEVEL_W-1:0] grade_of(input logic [SCORE_W-1:0] acc);
      if (acc == SCORE_W'(GRADE_SS))     return LEVEL_W'(5);
      else if (acc >= SCORE_W'(GRADE_S)) return LEVEL_W'(4);
      else if (acc >= SCORE_W'(GRADE_A)) return LEVEL_W'(3);
      else if (acc >= SCORE_W'(GRADE_B)) return LEVEL_W'(2);
      else if (acc >= SCORE_W'(GRADE_C)) return LEVEL_W'(1);
      else                               return LEVEL_W'(0);
   endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Hit handshake plus statistics bus between the note judge (master) and score_keeper (slave).
// full_combo exists only when SCORE_FULL_COMBO_EN is defined.
interface score_keeper_if;
   import score_keeper_pkg::*;

   logic               clear;
   logic               hit_valid;
   logic [1:0]         hit_judge;
   logic               hit_ready;
   logic [1:0]         mod;
   logic [3:0]         difficulty;
   logic [SCORE_W-1:0] combo;
   logic [SCORE_W-1:0] max_combo;
   logic [SCORE_W-1:0] base_score;
   logic [SCORE_W-1:0] bonus_score;
   logic [SCORE_W-1:0] acc;
   logic [LEVEL_W-1:0] level;
   logic               busy;
`ifdef SCORE_FULL_COMBO_EN
   logic               full_combo;
`endif

   modport master (
      output clear, hit_valid, hit_judge, mod, difficulty,
      input  hit_ready, combo, max_combo, base_score, bonus_score, acc, level, busy
`ifdef SCORE_FULL_COMBO_EN
      , input full_combo
`endif
   );

   modport slave (
      input  clear, hit_valid, hit_judge, mod, difficulty,
      output hit_ready, combo, max_combo, base_score, bonus_score, acc, level, busy
`ifdef SCORE_FULL_COMBO_EN
      , output full_combo
`endif
   );

endinterface

// File: rtl/score_keeper_serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, N_W cycles total, abortable by clear_i.
// The first bit is resolved in the start cycle; done_o pulses once the quotient is complete.
module score_keeper_serial_divider
   import score_keeper_pkg::*;
#(
   parameter int unsigned N_W = DIV_W,
   parameter int unsigned Q_W = SCORE_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear_i,
   input  logic           start_i,
   input  logic [N_W-1:0] numerator_i,
   input  logic [N_W-1:0] denominator_i,
   output logic           done_o,
   output logic [Q_W-1:0] quotient_o
);

   localparam int unsigned CNT_W = $clog2(N_W) + 1;

   logic [N_W-1:0]   rem_q, rem_d, quo_q, quo_d, den_q, den_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d, done_q, done_d;

   // quo holds the unconsumed numerator bits above the growing quotient
   function automatic logic [2*N_W-1:0] div_step(input logic [N_W-1:0] rem,
                                                 input logic [N_W-1:0] quo,
                                                 input logic [N_W-1:0] den);
      logic [N_W:0] trial;
      logic         q_bit;
      trial = {rem, quo[N_W-1]};
      q_bit = (trial >= {1'b0, den});
      if (q_bit) trial = trial - {1'b0, den};
      return {trial[N_W-1:0], quo[N_W-2:0], q_bit};
   endfunction

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      den_d  = den_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = 1'b0;
      if (clear_i) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start_i) begin
         den_d          = denominator_i;
         {rem_d, quo_d} = div_step('0, numerator_i, denominator_i);
         cnt_d          = CNT_W'(N_W - 1);
         run_d          = 1'b1;
      end else if (run_q) begin
         {rem_d, quo_d} = div_step(rem_q, quo_q, den_q);
         cnt_d          = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         den_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         den_q  <= den_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign done_o     = done_q;
   assign quotient_o = quo_q[Q_W-1:0];

endmodule

// File: rtl/score_keeper.sv
// Running combo/score/accuracy keeper feeding the scoreboard; back-pressures hits during division.
// Define SCORE_FULL_COMBO_EN to add full_combo tracking and the level-4 cap without it.
module score_keeper
   import score_keeper_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   score_keeper_if.slave bus
);

   logic [1:0]         state_q, state_d;
   logic [SCORE_W-1:0] combo_q, combo_d, max_combo_q, max_combo_d;
   logic [SCORE_W-1:0] base_q, base_d, bonus_q, bonus_d, acc_q, acc_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [NOTE_W-1:0]  note_cnt_q, note_cnt_d;
   logic [DIV_W-1:0]   acc_num_q, acc_num_d, acc_den_q, acc_den_d;
   logic               ready_q, ready_d, busy_q, busy_d;
   logic               fc_q, fc_d;
   logic               div_start, div_done, hit_ok;
   logic [SCORE_W-1:0] div_quotient, combo_inc;
   logic [7:0]         combo_capped;
   logic [11:0]        bonus_raw;
   logic [12:0]        bonus_mod;
   logic [LEVEL_W-1:0] grade;

   // Per-hit arithmetic from the pre-hit combo and the current mod/difficulty
   always_comb begin
      hit_ok       = (bus.hit_judge != JUDGE_MISS);
      combo_inc    = (combo_q == '1) ? combo_q : combo_q + SCORE_W'(1);
      combo_capped = (combo_q > SCORE_W'(COMBO_CAP)) ? 8'(COMBO_CAP) : combo_q[7:0];
      bonus_raw    = 12'(combo_capped) * 12'(bus.difficulty);
      case (bus.mod)
         MOD_X2:   bonus_mod = {bonus_raw, 1'b0};
         MOD_HALF: bonus_mod = 13'(bonus_raw >> 1);
         default:  bonus_mod = 13'(bonus_raw);
      endcase
      grade = grade_of(div_quotient);
`ifdef SCORE_FULL_COMBO_EN
      if (!fc_q && grade > LEVEL_W'(4)) grade = LEVEL_W'(4);
`endif
   end

   always_comb begin
      state_d     = state_q;
      combo_d     = combo_q;
      max_combo_d = max_combo_q;
      base_d      = base_q;
      bonus_d     = bonus_q;
      acc_d       = acc_q;
      level_d     = level_q;
      note_cnt_d  = note_cnt_q;
      acc_num_d   = acc_num_q;
      acc_den_d   = acc_den_q;
      fc_d        = fc_q;
      div_start   = 1'b0;
      if (bus.clear) begin
         state_d     = ST_IDLE;
         combo_d     = '0;
         max_combo_d = '0;
         base_d      = '0;
         bonus_d     = '0;
         acc_d       = '0;
         level_d     = '0;
         note_cnt_d  = '0;
         acc_num_d   = '0;
         acc_den_d   = '0;
         fc_d        = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.hit_valid && ready_q) begin
               state_d   = ST_UPDATE;
               div_start = 1'b1;
               if (hit_ok) begin
                  combo_d     = combo_inc;
                  max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
                  base_d      = sat_add(base_q, judge_points(bus.hit_judge));
                  bonus_d     = sat_add(bonus_q, SCORE_W'(bonus_mod));
               end else begin
                  combo_d = '0;
               end
               fc_d = (note_cnt_q == '0) ? hit_ok : (fc_q && hit_ok);
               // Accuracy counters freeze at the note cap; the divider reruns on the frozen values
               if (note_cnt_q != NOTE_CAP) begin
                  note_cnt_d = note_cnt_q + NOTE_W'(1);
                  acc_num_d  = acc_num_q + DIV_W'(ACC_SCALE) * DIV_W'(judge_weight(bus.hit_judge));
                  acc_den_d  = acc_den_q + DIV_W'(DEN_STEP);
               end
            end
            ST_UPDATE: state_d = ST_DIVIDE;
            ST_DIVIDE: if (div_done) state_d = ST_GRADE;
            ST_GRADE: begin
               acc_d   = div_quotient;
               level_d = grade;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      ready_d = (state_d == ST_IDLE);
      busy_d  = ~ready_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         combo_q     <= '0;
         max_combo_q <= '0;
         base_q      <= '0;
         bonus_q     <= '0;
         acc_q       <= '0;
         level_q     <= '0;
         note_cnt_q  <= '0;
         acc_num_q   <= '0;
         acc_den_q   <= '0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         fc_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         combo_q     <= combo_d;
         max_combo_q <= max_combo_d;
         base_q      <= base_d;
         bonus_q     <= bonus_d;
         acc_q       <= acc_d;
         level_q     <= level_d;
         note_cnt_q  <= note_cnt_d;
         acc_num_q   <= acc_num_d;
         acc_den_q   <= acc_den_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         fc_q        <= fc_d;
      end
   end

   score_keeper_serial_divider #(.N_W(DIV_W), .Q_W(SCORE_W)) u_div (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (bus.clear),
      .start_i      (div_start),
      .numerator_i  (acc_num_d),
      .denominator_i(acc_den_d),
      .done_o       (div_done),
      .quotient_o   (div_quotient)
   );

   assign bus.hit_ready   = ready_q;
   assign bus.busy        = busy_q;
   assign bus.combo       = combo_q;
   assign bus.max_combo   = max_combo_q;
   assign bus.base_score  = base_q;
   assign bus.bonus_score = bonus_q;
   assign bus.acc         = acc_q;
   assign bus.level       = level_q;
`ifdef SCORE_FULL_COMBO_EN
   assign bus.full_combo  = fc_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a reference model pushes expectations at drive time,
// which are popped and compared when the DUT presents scores (N+1) and accuracy (N+34).
module tb_score_keeper;
   import score_keeper_pkg::*;

   localparam longint MAXV = (longint'(1) << SCORE_W) - 1;

   typedef struct {
      longint combo, maxc, base, bonus, acc, level;
      bit     fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   score_keeper_if intf ();
   score_keeper dut (.clk(clk), .rst_n(rst_n), .bus(intf.slave));

   int     n_checks = 0;
   int     n_errors = 0;
   exp_t   sb[$];
   longint m_combo, m_max, m_base, m_bonus, m_note, m_num, m_den;
   bit     m_fc;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_combo = 0; m_max = 0; m_base = 0; m_bonus = 0;
      m_note = 0; m_num = 0; m_den = 0; m_fc = 0;
   endfunction

   function automatic void model_hit(input int j, input int md, input int d);
      longint add, pts;
      m_fc = (m_note == 0) ? (j != 0) : (m_fc && (j != 0));
      if (j == 0) m_combo = 0;
      else begin
         pts = (j == 3) ? 300 : (j == 2) ? 100 : 50;
         add = ((m_combo < 255) ? m_combo : 255) * d;
         if (md == 1) add = add * 2;
         else if (md == 2) add = add / 2;
         m_base  = (m_base + pts > MAXV) ? MAXV : m_base + pts;
         m_bonus = (m_bonus + add > MAXV) ? MAXV : m_bonus + add;
         m_combo = (m_combo == MAXV) ? MAXV : m_combo + 1;
         if (m_combo > m_max) m_max = m_combo;
      end
      if (m_note < 65535) begin
         m_note++;
         m_num += 10000 * j;
         m_den += 3;
      end
   endfunction

   function automatic exp_t model_expect();
      exp_t e;
      e.combo = m_combo; e.maxc = m_max; e.base = m_base; e.bonus = m_bonus; e.fc = m_fc;
      e.acc   = (m_den == 0) ? 0 : m_num / m_den;
      if (e.acc == 10000)    e.level = 5;
      else if (e.acc >= 9500) e.level = 4;
      else if (e.acc >= 9000) e.level = 3;
      else if (e.acc >= 8000) e.level = 2;
      else if (e.acc >= 7000) e.level = 1;
      else                    e.level = 0;
`ifdef SCORE_FULL_COMBO_EN
      if (!m_fc && e.level > 4) e.level = 4;
`endif
      return e;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!intf.hit_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!intf.hit_ready) check("ready_timeout", intf.hit_ready, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_combo"}, intf.combo, 0);
      check({tag, "_max"}, intf.max_combo, 0);
      check({tag, "_base"}, intf.base_score, 0);
      check({tag, "_bonus"}, intf.bonus_score, 0);
      check({tag, "_acc"}, intf.acc, 0);
      check({tag, "_level"}, intf.level, 0);
      check({tag, "_ready"}, intf.hit_ready, 1);
      check({tag, "_busy"}, intf.busy, 0);
`ifdef SCORE_FULL_COMBO_EN
      check({tag, "_fc"}, intf.full_combo, 0);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      intf.clear = 1'b0; intf.hit_valid = 1'b0; intf.hit_judge = 2'b00;
      intf.mod = 2'b00; intf.difficulty = 4'd0;
      model_reset();
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send_hit(input int j, input int md, input int d);
      exp_t e;
      int   cyc;
      wait_ready();
      @(negedge clk);
      intf.hit_valid = 1'b1;
      intf.hit_judge = 2'(j);
      intf.mod = 2'(md);
      intf.difficulty = 4'(d);
      model_hit(j, md, d);
      sb.push_back(model_expect());
      @(posedge clk); #1;
      intf.hit_valid  = 1'b0;
      intf.mod        = 2'($urandom);
      intf.difficulty = 4'($urandom);
      e = sb.pop_front();
      check("combo", intf.combo, e.combo);
      check("max_combo", intf.max_combo, e.maxc);
      check("base", intf.base_score, e.base);
      check("bonus", intf.bonus_score, e.bonus);
      check("ready_low", intf.hit_ready, 0);
      check("busy_high", intf.busy, 1);
`ifdef SCORE_FULL_COMBO_EN
      check("full_combo", intf.full_combo, longint'(e.fc));
`endif
      cyc = 1;
      while (!intf.hit_ready && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, 34);
      check("acc", intf.acc, e.acc);
      check("level", intf.level, e.level);
      check("busy_low", intf.busy, 0);
   endtask

   initial begin
      exp_t e;
      do_reset();

      // Single perfect, then perfect + great
      send_hit(3, 0, 4);
      check("tp1_acc", intf.acc, 10000);
      check("tp1_level", intf.level, 5);
      send_hit(2, 0, 4);
      check("tp2_base", intf.base_score, 400);
      check("tp2_bonus", intf.bonus_score, 4);
      check("tp2_acc", intf.acc, 8333);
      check("tp2_level", intf.level, 2);

      // Combo bonus with x2 mod, then a miss, then halved bonus
      do_reset();
      repeat (10) send_hit(3, 0, 4);
      send_hit(3, 1, 4);
      check("tp3_bonus", intf.bonus_score, 260);
      send_hit(0, 0, 4);
      check("tp3_combo", intf.combo, 0);
      check("tp3_max", intf.max_combo, 11);
      check("tp3_base", intf.base_score, 3300);
      send_hit(1, 2, 7);
      send_hit(1, 2, 7);

      // hit_valid held through a whole division: exactly two acceptances in 40 cycles
      wait_ready();
      @(negedge clk);
      intf.hit_valid = 1'b1; intf.hit_judge = 2'd3; intf.mod = 2'd0; intf.difficulty = 4'd2;
      model_hit(3, 0, 2);
      sb.push_back(model_expect());
      @(posedge clk); #1;
      e = sb.pop_front();
      check("held_combo1", intf.combo, e.combo);
      model_hit(3, 0, 2);
      sb.push_back(model_expect());
      repeat (39) @(posedge clk);
      #1;
      intf.hit_valid = 1'b0;
      check("held_busy", intf.busy, 1);
      wait_ready();
      e = sb.pop_front();
      check("held_combo2", intf.combo, e.combo);
      check("held_base", intf.base_score, e.base);
      check("held_bonus", intf.bonus_score, e.bonus);
      check("held_acc", intf.acc, e.acc);
      check("held_level", intf.level, e.level);

      // clear 10 cycles into DIVIDE aborts the division
      @(negedge clk);
      intf.hit_valid = 1'b1; intf.hit_judge = 2'd3;
      @(posedge clk); #1;
      intf.hit_valid = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      intf.clear = 1'b1;
      @(posedge clk); #1;
      check_all_zero("clear");
      @(negedge clk);
      intf.clear = 1'b0;
      model_reset();
      repeat (40) @(posedge clk);
      #1;
      check("clear_acc_hold", intf.acc, 0);
      check("clear_level_hold", intf.level, 0);
      check("clear_ready_hold", intf.hit_ready, 1);

      // Full-combo broken by a miss
      send_hit(3, 0, 3);
      send_hit(3, 0, 3);
      send_hit(0, 0, 3);
      repeat (3) send_hit(3, 0, 3);
`ifdef SCORE_FULL_COMBO_EN
      check("fc_broken", intf.full_combo, 0);
      check("fc_level_cap", (intf.level <= 3'd4) ? 1 : 0, 1);
`endif

      // Bonus saturation at 2^SCORE_W-1
      do_reset();
      for (int i = 0; i < 420; i++) send_hit(3, 1, 15);
      check("sat_bonus", intf.bonus_score, MAXV);
      send_hit(3, 1, 15);
      check("sat_bonus_hold", intf.bonus_score, MAXV);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
